// File: rtl/chi_inv_seq.sv
`default_nettype none
// ============================================================================
// Module   : chi_inv_seq
// Brief    : Iterative inverse of the Keccak Chi step, Z_PER_CYCLE z-slices
//            per clock through replicated 32x5 inverse lookup tables.
// Revision : 1.0 - initial release
// ============================================================================
module chi_inv_seq #(
    parameter int Z_PER_CYCLE = 8
) (
    input  logic          inClk,
    input  logic          inRst,
    input  logic          inStart,
    input  logic [1599:0] inData,
    output logic [1599:0] outData,
    output logic          outValid,
    output logic          outBusy
);

    localparam int N_STEPS = 64 / Z_PER_CYCLE;
    localparam int CW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    generate
        if (!(Z_PER_CYCLE == 1 || Z_PER_CYCLE == 2 || Z_PER_CYCLE == 4 ||
              Z_PER_CYCLE == 8 || Z_PER_CYCLE == 16 || Z_PER_CYCLE == 32 ||
              Z_PER_CYCLE == 64)) begin : g_bad_z_per_cycle
            $error("chi_inv_seq: Z_PER_CYCLE must be a power of two in 1..64");
        end
    endgenerate

    function automatic logic [4:0] chi_row(input logic [4:0] a);
        logic [4:0] b;
        for (int x = 0; x < 5; x++) begin
            b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
        end
        return b;
    endfunction

    // Entry b holds the unique a with chi(a) == b; built once at elaboration.
    function automatic logic [159:0] build_inv();
        logic [159:0] t;
        logic [4:0]   b;
        t = '0;
        for (int a = 0; a < 32; a++) begin
            b = chi_row(5'(a));
            t[int'(b) * 5 +: 5] = 5'(a);
        end
        return t;
    endfunction

    localparam logic [159:0] INV_TBL = build_inv();
    localparam logic [CW-1:0] LAST_STEP = CW'(N_STEPS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1599:0]   src_q;
    logic [1599:0]   work_q;
    logic [1599:0]   work_d;
    logic [1599:0]   out_q;
    logic            valid_q;
    logic            busy_q;

    logic [4:0]      row;
    logic [4:0]      res;
    int              zi;

    always_comb begin
        work_d = work_q;
        row    = '0;
        res    = '0;
        zi     = 0;
        for (int y = 0; y < 5; y++) begin
            for (int j = 0; j < Z_PER_CYCLE; j++) begin
                zi = int'(cnt_q) * Z_PER_CYCLE + j;
                for (int x = 0; x < 5; x++) begin
                    row[x] = src_q[64 * (x + 5 * y) + zi];
                end
                res = INV_TBL[int'(row) * 5 +: 5];
                for (int x = 0; x < 5; x++) begin
                    work_d[64 * (x + 5 * y) + zi] = res[x];
                end
            end
        end
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inStart) begin
                        src_q   <= inData;
                        cnt_q   <= '0;
                        work_q  <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    work_q <= work_d;
                    if (cnt_q == LAST_STEP) begin
                        out_q   <= work_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign outData  = out_q;
    assign outValid = valid_q;
    assign outBusy  = busy_q;

endmodule
`default_nettype wire
